ascon_decrypt_top: RTL and testbench
====================================

# ascon_decrypt_top

Ascon-128 authenticated-decryption engine: the receive-side counterpart of the encryption top. Takes key, nonce, one associated-data block and a stream of 64-bit ciphertext blocks. Returns plaintext blocks, recomputes the 128-bit tag and compares it to the received tag. Contains its own state register, round counter, block counter and control FSM, and reuses the team's single-round permutation layers (constant addition, S-box, linear diffusion) from `ascon_pack`.

## Interface
- NB_BLOCKS, 3, number of ciphertext blocks per message (1..15)
- clock_i  in  1  system clock, rising edge
- resetb_i  in  1  asynchronous active-low reset
- start_i  in  1  start a new message; sampled only in IDLE or DONE
- key_i  in  128  key K; held stable from start_i until end_o
- nonce_i  in  128  nonce N; sampled on start_i
- data_i  in  64  AD block first, then ciphertext blocks C0..C(NB_BLOCKS-1)
- data_valid_i  in  1  data_i valid; one cycle per block
- tag_i  in  128  received tag; sampled on the last ciphertext acceptance
- ready_o  out  1  block accepts data_valid_i this cycle
- plain_o  out  64  recovered plaintext block
- plain_valid_o  out  1  one-cycle pulse, plain_o valid
- tag_o  out  128  recomputed tag
- auth_ok_o  out  1  tag_o == received tag; valid while end_o=1
- end_o  out  1  message finished; held high in DONE

## Operation
- State S0..S4 (64 bit each); S0 is the rate word.
- Round constant for round index r (0..11): ((15-r)<<4) | r, XORed into the low byte of S2.
- FSM states: IDLE, INIT, WAIT_AD, PB_AD, WAIT_CT, PB_CT, FINAL, DONE.
- IDLE/DONE + start_i: load S = IV 0x80400C0600000000 || K || N, r=0, block counter=0, clear end_o/auth_ok_o, go INIT.
- INIT: one round per cycle, r=0..11. At r=11 the round output has K XORed into S3||S4. Then go WAIT_AD.
- WAIT_AD, ready_o=1, data_valid_i: S0 ^= data_i, r=6, go PB_AD.
- PB_AD: rounds r=6..11. At r=11 the output has S4 ^= 1 (domain separation). Then go WAIT_CT.
- WAIT_CT, ready_o=1, data_valid_i with C:
  - plain_o <= S0 ^ C, pulse plain_valid_o, S0 <= C (replace, not XOR).
  - If block counter < NB_BLOCKS-1: increment the counter, r=6, go PB_CT.
  - Otherwise, in the same write: S1||S2 ^= K, latch tag_i, r=0, go FINAL.
- PB_CT: rounds r=6..11, then go WAIT_CT.
- FINAL: rounds r=0..11. At r=11:
  - tag_o <= (S3||S4 of the round output) ^ K.
  - auth_ok_o <= (that value == latched tag).
  - Go DONE.
- DONE: end_o=1; tag_o and auth_ok_o held; the last plain_o is held.
- Boundary rules:
  - start_i outside IDLE/DONE: ignored.
  - data_valid_i outside WAIT_AD/WAIT_CT: ignored, no state change.
  - start_i and data_valid_i together in IDLE: start wins.
  - Block counter never wraps inside a message; it is cleared on start.
  - Plaintext is released before authentication. The consumer discards it when auth_ok_o=0.

## Timing
- Reset values: FSM=IDLE, S=0, r=0, block counter=0. All outputs 0: ready_o, plain_o, plain_valid_o, tag_o, auth_ok_o, end_o.
- Reset mid-operation: immediate return to reset values. No output pulse follows.
- start_i accepted at edge E0:
  - INIT occupies E1..E12.
  - ready_o=1 from the cycle after E12.
- AD accepted at edge A: PB_AD occupies A+1..A+6, ready_o high after A+6.
- Non-last ciphertext accepted at edge C:
  - plain_valid_o high for the cycle after C.
  - PB_CT occupies C+1..C+6.
- Last ciphertext accepted at edge L:
  - plain_valid_o after L.
  - FINAL occupies L+1..L+12.
  - end_o, tag_o and auth_ok_o valid from the cycle after L+12.
- Minimum message (NB_BLOCKS=3, data_valid_i asserted as soon as ready_o rises): 1+12+1+6+(1+6)·2+1+12 = 47 edges from start to end_o.
- ready_o is registered and deasserts the cycle after acceptance.

## Test plan
- Round trip with the encryptor:
  - Stimulus: K=0x000102…0F, N=0x101112…1F, AD=0x0001020304050607, P0..P2=0x3230323380000000, 0x1122334455667788, 0x99AABBCCDDEEFF00. Encrypt them on the encryption top, then feed the resulting C and tag here.
  - Response: plain_o pulses equal P0..P2 in order, tag_o equals the encryptor tag, auth_ok_o=1, end_o rises 47 cycles after start.
- Tampered tag: same stimulus with tag_i bit 0 flipped -> plaintext unchanged, tag_o unchanged, auth_ok_o=0, end_o=1.
- Tampered ciphertext: C1 bit 63 flipped:
  - plain_o for block 1 differs from P1 in bit 63 only.
  - Block 2 plaintext differs from P2.
  - auth_ok_o=0.
- Protocol robustness, with a 5-cycle gap before each data_valid_i:
  - data_valid_i pulsed during INIT/PB/FINAL -> ignored.
  - start_i pulsed mid-message -> ignored.
  - Final outputs match the round-trip case.
- Reset mid-FINAL: resetb_i low for one cycle -> all outputs 0, FSM in IDLE. A new start then reproduces the round-trip result.
- Back-to-back messages: start_i in DONE -> end_o and auth_ok_o clear the next cycle. A second message with a different nonce authenticates correctly.

Source files
------------

// File: rtl/ascon_decrypt_top_if.sv
// Bus bundle for the Ascon-128 decryption engine.
// Carries: start/key/nonce, 64-bit AD/ciphertext stream with valid/ready,
// received tag in; plaintext with valid pulse, recomputed tag, auth flag and end out.
interface ascon_decrypt_top_if;
  logic         start_i;
  logic [127:0] key_i;
  logic [127:0] nonce_i;
  logic [63:0]  data_i;
  logic         data_valid_i;
  logic [127:0] tag_i;
  logic         ready_o;
  logic [63:0]  plain_o;
  logic         plain_valid_o;
  logic [127:0] tag_o;
  logic         auth_ok_o;
  logic         end_o;

  // Message source / result sink side.
  modport master (
    output start_i, key_i, nonce_i, data_i, data_valid_i, tag_i,
    input  ready_o, plain_o, plain_valid_o, tag_o, auth_ok_o, end_o
  );

  // Decryption engine side.
  modport slave (
    input  start_i, key_i, nonce_i, data_i, data_valid_i, tag_i,
    output ready_o, plain_o, plain_valid_o, tag_o, auth_ok_o, end_o
  );
endinterface

// File: rtl/ascon_decrypt_top.sv
// Ascon-128 authenticated decryption: init, one AD block, NB_BLOCKS ciphertext
// blocks, finalisation and tag compare; one permutation round per cycle.
// Ports: clock_i (rising edge), resetb_i (async active-low), bus (slave modport):
//   start/key/nonce/data/data_valid/tag in; ready/plain/plain_valid/tag/auth_ok/end out.
module ascon_decrypt_top #(
  parameter int NB_BLOCKS = 3
) (
  input  logic                 clock_i,
  input  logic                 resetb_i,
  ascon_decrypt_top_if.slave   bus
);

  typedef logic [4:0][63:0] ascon_state_t;  // element i is S<i>, S0 = rate word

  typedef enum logic [2:0] {
    IDLE, INIT, WAIT_AD, PB_AD, WAIT_CT, PB_CT, FINAL, DONE
  } fsm_t;

  localparam logic [63:0] IV       = 64'h80400C0600000000;
  localparam logic [3:0]  LAST_BLK = 4'(NB_BLOCKS - 1);
  localparam logic [3:0]  LAST_RND = 4'd11;

  function automatic logic [63:0] ror64(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // One Ascon round: constant addition, bitsliced S-box, linear diffusion.
  function automatic ascon_state_t ascon_round(input ascon_state_t s, input logic [3:0] r);
    ascon_state_t x;
    logic [63:0]  t0, t1, t2, t3, t4;
    x = s;
    x[2][7:0] = x[2][7:0] ^ {4'hF - r, r};
    x[0] = x[0] ^ x[4];
    x[4] = x[4] ^ x[3];
    x[2] = x[2] ^ x[1];
    t0 = ~x[0] & x[1];
    t1 = ~x[1] & x[2];
    t2 = ~x[2] & x[3];
    t3 = ~x[3] & x[4];
    t4 = ~x[4] & x[0];
    x[0] = x[0] ^ t1;
    x[1] = x[1] ^ t2;
    x[2] = x[2] ^ t3;
    x[3] = x[3] ^ t4;
    x[4] = x[4] ^ t0;
    x[1] = x[1] ^ x[0];
    x[0] = x[0] ^ x[4];
    x[3] = x[3] ^ x[2];
    x[2] = ~x[2];
    x[0] = x[0] ^ ror64(x[0], 19) ^ ror64(x[0], 28);
    x[1] = x[1] ^ ror64(x[1], 61) ^ ror64(x[1], 39);
    x[2] = x[2] ^ ror64(x[2], 1)  ^ ror64(x[2], 6);
    x[3] = x[3] ^ ror64(x[3], 10) ^ ror64(x[3], 17);
    x[4] = x[4] ^ ror64(x[4], 7)  ^ ror64(x[4], 41);
    return x;
  endfunction

  fsm_t         state_q, state_n;
  ascon_state_t s_q, s_step;
  logic [3:0]   rnd_q;
  logic [3:0]   blk_q;
  logic [127:0] tag_rx_q;
  logic [127:0] tag_calc;
  logic         ready_q, plain_vld_q, auth_q, end_q;
  logic [63:0]  plain_q;
  logic [127:0] tag_q;

  assign bus.ready_o       = ready_q;
  assign bus.plain_o       = plain_q;
  assign bus.plain_valid_o = plain_vld_q;
  assign bus.tag_o         = tag_q;
  assign bus.auth_ok_o     = auth_q;
  assign bus.end_o         = end_q;

  // Round output with the key / domain-separation injections that close INIT and PB_AD.
  always_comb begin
    s_step = ascon_round(s_q, rnd_q);
    if (rnd_q == LAST_RND) begin
      if (state_q == INIT) begin
        s_step[3] = s_step[3] ^ bus.key_i[127:64];
        s_step[4] = s_step[4] ^ bus.key_i[63:0];
      end else if (state_q == PB_AD) begin
        s_step[4][0] = ~s_step[4][0];
      end
    end
  end

  assign tag_calc = {s_step[3], s_step[4]} ^ bus.key_i;

  // Next-state logic.
  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE, DONE: if (bus.start_i) state_n = INIT;
      INIT:       if (rnd_q == LAST_RND) state_n = WAIT_AD;
      WAIT_AD:    if (bus.data_valid_i) state_n = PB_AD;
      PB_AD:      if (rnd_q == LAST_RND) state_n = WAIT_CT;
      WAIT_CT:    if (bus.data_valid_i) state_n = (blk_q < LAST_BLK) ? PB_CT : FINAL;
      PB_CT:      if (rnd_q == LAST_RND) state_n = WAIT_CT;
      FINAL:      if (rnd_q == LAST_RND) state_n = DONE;
      default:    state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state_q     <= IDLE;
      s_q         <= '0;
      rnd_q       <= '0;
      blk_q       <= '0;
      tag_rx_q    <= '0;
      ready_q     <= 1'b0;
      plain_q     <= '0;
      plain_vld_q <= 1'b0;
      tag_q       <= '0;
      auth_q      <= 1'b0;
      end_q       <= 1'b0;
    end else begin
      state_q     <= state_n;
      // Registered ready: high exactly while sitting in a WAIT state.
      ready_q     <= (state_n == WAIT_AD) || (state_n == WAIT_CT);
      plain_vld_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (bus.start_i) begin
            s_q    <= {bus.nonce_i[63:0], bus.nonce_i[127:64],
                       bus.key_i[63:0], bus.key_i[127:64], IV};
            rnd_q  <= '0;
            blk_q  <= '0;
            end_q  <= 1'b0;
            auth_q <= 1'b0;
          end
        end
        INIT, PB_AD, PB_CT: begin
          s_q   <= s_step;
          rnd_q <= rnd_q + 4'd1;
        end
        WAIT_AD: begin
          if (bus.data_valid_i) begin
            s_q[0] <= s_q[0] ^ bus.data_i;
            rnd_q  <= 4'd6;
          end
        end
        WAIT_CT: begin
          if (bus.data_valid_i) begin
            plain_q     <= s_q[0] ^ bus.data_i;
            plain_vld_q <= 1'b1;
            // Decryption replaces the rate with the ciphertext so the sponge
            // state tracks the encryptor exactly.
            s_q[0]      <= bus.data_i;
            if (blk_q < LAST_BLK) begin
              blk_q <= blk_q + 4'd1;
              rnd_q <= 4'd6;
            end else begin
              s_q[1]   <= s_q[1] ^ bus.key_i[127:64];
              s_q[2]   <= s_q[2] ^ bus.key_i[63:0];
              tag_rx_q <= bus.tag_i;
              rnd_q    <= '0;
            end
          end
        end
        FINAL: begin
          s_q   <= s_step;
          rnd_q <= rnd_q + 4'd1;
          if (rnd_q == LAST_RND) begin
            tag_q  <= tag_calc;
            auth_q <= (tag_calc == tag_rx_q);
            end_q  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ascon_decrypt_top.sv
module tb_ascon_decrypt_top;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ascon_decrypt_top_if bus();
  ascon_decrypt_top #(.NB_BLOCKS(3)) dut (.clock_i(clk), .resetb_i(rst_n), .bus(bus));

  typedef logic [4:0][63:0] st_t;

  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

  logic [127:0] key    = 128'h000102030405060708090A0B0C0D0E0F;
  logic [127:0] nonce  = 128'h101112131415161718191A1B1C1D1E1F;
  logic [127:0] nonce2 = 128'h202122232425262728292A2B2C2D2E2F;
  logic [63:0]  ad     = 64'h0001020304050607;
  logic [63:0]  p0     = 64'h3230323380000000;
  logic [63:0]  p1     = 64'h1122334455667788;
  logic [63:0]  p2     = 64'h99AABBCCDDEEFF00;
  logic [63:0]  bit63  = 64'h8000000000000000;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int pv_seen = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.plain_valid_o === 1'b1) pv_seen <= pv_seen + 1;
  end

  // Reference model: table-driven S-box, rotation by doubling the word.
  function automatic logic [63:0] rot(input logic [63:0] v, input int n);
    logic [127:0] d;
    d = {v, v} >> n;
    return d[63:0];
  endfunction

  function automatic st_t tb_perm(input st_t s, input int first);
    st_t x;
    logic [4:0] v;
    x = s;
    for (int r = first; r < 12; r++) begin
      x[2] = x[2] ^ 64'((15 - r) * 16 + r);
      for (int b = 0; b < 64; b++) begin
        v = SBOX[{x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]}];
        {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]} = v;
      end
      x[0] = x[0] ^ rot(x[0], 19) ^ rot(x[0], 28);
      x[1] = x[1] ^ rot(x[1], 61) ^ rot(x[1], 39);
      x[2] = x[2] ^ rot(x[2], 1)  ^ rot(x[2], 6);
      x[3] = x[3] ^ rot(x[3], 10) ^ rot(x[3], 17);
      x[4] = x[4] ^ rot(x[4], 7)  ^ rot(x[4], 41);
    end
    return x;
  endfunction

  task automatic model_enc(input logic [127:0] n, output logic [63:0] o0, o1, o2,
                           output logic [127:0] t);
    st_t x;
    x[0] = 64'h80400C0600000000;
    x[1] = key[127:64];
    x[2] = key[63:0];
    x[3] = n[127:64];
    x[4] = n[63:0];
    x = tb_perm(x, 0);
    x[3] = x[3] ^ key[127:64];
    x[4] = x[4] ^ key[63:0];
    x[0] = x[0] ^ ad;
    x = tb_perm(x, 6);
    x[4] = x[4] ^ 64'd1;
    o0 = x[0] ^ p0; x[0] = o0; x = tb_perm(x, 6);
    o1 = x[0] ^ p1; x[0] = o1; x = tb_perm(x, 6);
    o2 = x[0] ^ p2; x[0] = o2;
    x[1] = x[1] ^ key[127:64];
    x[2] = x[2] ^ key[63:0];
    x = tb_perm(x, 0);
    t = {x[3], x[4]} ^ key;
  endtask

  // Drives one message; returns observations, performs no comparisons.
  task automatic drive_msg(input logic [127:0] n, input logic [63:0] c0, c1, c2,
                           input logic [127:0] tg, input int gap, input bit noise,
                           input bit abort, output logic [63:0] pl0, pl1, pl2,
                           output int edges, output int pv_cnt, output bit to_err,
                           output logic e_after, output logic a_after);
    logic [63:0] blk;
    int t0, pv0, w;
    to_err = 1'b0; pl0 = '0; pl1 = '0; pl2 = '0; edges = 0; pv_cnt = 0;
    @(negedge clk);
    bus.nonce_i = n; bus.start_i = 1'b1;
    bus.data_valid_i = 1'b1; bus.data_i = 64'hDEADBEEFDEADBEEF;
    @(negedge clk);
    t0 = cyc; pv0 = pv_seen;
    bus.start_i = 1'b0; bus.data_valid_i = 1'b0;
    e_after = bus.end_o; a_after = bus.auth_ok_o;
    for (int k = 0; k < 4; k++) begin
      blk = (k == 0) ? ad : (k == 1) ? c0 : (k == 2) ? c1 : c2;
      w = 0;
      while (bus.ready_o !== 1'b1 && w < 40) begin
        if (noise && w == 2) begin
          bus.data_valid_i = 1'b1; bus.data_i = ~blk;
          if (k == 2) bus.start_i = 1'b1;
        end
        @(negedge clk);
        bus.data_valid_i = 1'b0; bus.start_i = 1'b0;
        w++;
      end
      if (w >= 40) begin to_err = 1'b1; return; end
      repeat (gap) @(negedge clk);
      bus.data_valid_i = 1'b1; bus.data_i = blk;
      if (k == 3) bus.tag_i = tg;
      @(negedge clk);
      bus.data_valid_i = 1'b0;
      if (k == 1) pl0 = bus.plain_o;
      if (k == 2) pl1 = bus.plain_o;
      if (k == 3) pl2 = bus.plain_o;
    end
    if (abort) begin repeat (5) @(negedge clk); return; end
    w = 0;
    while (bus.end_o !== 1'b1 && w < 40) begin
      if (noise && w == 3) begin bus.data_valid_i = 1'b1; bus.data_i = 64'h5A5A; end
      @(negedge clk);
      bus.data_valid_i = 1'b0;
      w++;
    end
    if (w >= 40) to_err = 1'b1;
    edges = cyc - t0 + 1;
    pv_cnt = pv_seen - pv0;
  endtask

  logic [63:0]  c0, c1, c2, q0, q1, q2;
  logic [127:0] tg;
  int  edges, pvc;
  bit  to_err;
  logic e_after, a_after;

  task automatic test_reset();
    bus.start_i = 1'b0; bus.data_valid_i = 1'b0; bus.data_i = '0;
    bus.key_i = key; bus.nonce_i = nonce; bus.tag_i = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_chk++; if (bus.ready_o !== 1'b0) $display("FAIL rst_ready: got %b want 0", bus.ready_o); else n_pass++;
    n_chk++; if (bus.plain_o !== 64'd0) $display("FAIL rst_plain: got %h want 0", bus.plain_o); else n_pass++;
    n_chk++; if (bus.plain_valid_o !== 1'b0) $display("FAIL rst_pvld: got %b want 0", bus.plain_valid_o); else n_pass++;
    n_chk++; if (bus.tag_o !== 128'd0) $display("FAIL rst_tag: got %h want 0", bus.tag_o); else n_pass++;
    n_chk++; if (bus.auth_ok_o !== 1'b0) $display("FAIL rst_auth: got %b want 0", bus.auth_ok_o); else n_pass++;
    n_chk++; if (bus.end_o !== 1'b0) $display("FAIL rst_end: got %b want 0", bus.end_o); else n_pass++;
    bus.data_valid_i = 1'b1; bus.data_i = 64'hFFFF;
    @(negedge clk);
    bus.data_valid_i = 1'b0;
    @(negedge clk);
    n_chk++; if (bus.ready_o !== 1'b0) $display("FAIL idle_dv_ready: got %b want 0", bus.ready_o); else n_pass++;
    n_chk++; if (bus.plain_valid_o !== 1'b0 || bus.plain_o !== 64'd0)
      $display("FAIL idle_dv_plain: got %b/%h want 0/0", bus.plain_valid_o, bus.plain_o); else n_pass++;
  endtask

  task automatic test_roundtrip();
    model_enc(nonce, c0, c1, c2, tg);
    drive_msg(nonce, c0, c1, c2, tg, 0, 1'b0, 1'b0, q0, q1, q2, edges, pvc, to_err, e_after, a_after);
    n_chk++; if (to_err) $display("FAIL rt_timeout: got timeout want completion"); else n_pass++;
    n_chk++; if (q0 !== p0) $display("FAIL rt_p0: got %h want %h", q0, p0); else n_pass++;
    n_chk++; if (q1 !== p1) $display("FAIL rt_p1: got %h want %h", q1, p1); else n_pass++;
    n_chk++; if (q2 !== p2) $display("FAIL rt_p2: got %h want %h", q2, p2); else n_pass++;
    n_chk++; if (bus.tag_o !== tg) $display("FAIL rt_tag: got %h want %h", bus.tag_o, tg); else n_pass++;
    n_chk++; if (bus.auth_ok_o !== 1'b1) $display("FAIL rt_auth: got %b want 1", bus.auth_ok_o); else n_pass++;
    n_chk++; if (edges != 47) $display("FAIL rt_latency: got %0d want 47", edges); else n_pass++;
    n_chk++; if (pvc != 3) $display("FAIL rt_pvld_count: got %0d want 3", pvc); else n_pass++;
    repeat (3) @(negedge clk);
    n_chk++; if (bus.end_o !== 1'b1 || bus.plain_o !== p2)
      $display("FAIL rt_done_hold: got end=%b plain=%h want 1/%h", bus.end_o, bus.plain_o, p2); else n_pass++;
  endtask

  task automatic test_bad_tag();
    model_enc(nonce, c0, c1, c2, tg);
    drive_msg(nonce, c0, c1, c2, tg ^ 128'd1, 0, 1'b0, 1'b0, q0, q1, q2, edges, pvc, to_err, e_after, a_after);
    n_chk++; if (to_err) $display("FAIL bt_timeout: got timeout want completion"); else n_pass++;
    n_chk++; if (q0 !== p0 || q1 !== p1 || q2 !== p2)
      $display("FAIL bt_plain: got %h %h %h want %h %h %h", q0, q1, q2, p0, p1, p2); else n_pass++;
    n_chk++; if (bus.tag_o !== tg) $display("FAIL bt_tag: got %h want %h", bus.tag_o, tg); else n_pass++;
    n_chk++; if (bus.auth_ok_o !== 1'b0) $display("FAIL bt_auth: got %b want 0", bus.auth_ok_o); else n_pass++;
    n_chk++; if (bus.end_o !== 1'b1) $display("FAIL bt_end: got %b want 1", bus.end_o); else n_pass++;
  endtask

  task automatic test_bad_ct();
    model_enc(nonce, c0, c1, c2, tg);
    drive_msg(nonce, c0, c1 ^ bit63, c2, tg, 0, 1'b0, 1'b0, q0, q1, q2, edges, pvc, to_err, e_after, a_after);
    n_chk++; if (to_err) $display("FAIL bc_timeout: got timeout want completion"); else n_pass++;
    n_chk++; if (q0 !== p0) $display("FAIL bc_p0: got %h want %h", q0, p0); else n_pass++;
    n_chk++; if (q1 !== (p1 ^ bit63)) $display("FAIL bc_p1: got %h want %h", q1, p1 ^ bit63); else n_pass++;
    n_chk++; if (q2 === p2) $display("FAIL bc_p2: got %h want a value differing from %h", q2, p2); else n_pass++;
    n_chk++; if (bus.auth_ok_o !== 1'b0) $display("FAIL bc_auth: got %b want 0", bus.auth_ok_o); else n_pass++;
  endtask

  task automatic test_robust();
    model_enc(nonce, c0, c1, c2, tg);
    drive_msg(nonce, c0, c1, c2, tg, 5, 1'b1, 1'b0, q0, q1, q2, edges, pvc, to_err, e_after, a_after);
    n_chk++; if (to_err) $display("FAIL rb_timeout: got timeout want completion"); else n_pass++;
    n_chk++; if (q0 !== p0 || q1 !== p1 || q2 !== p2)
      $display("FAIL rb_plain: got %h %h %h want %h %h %h", q0, q1, q2, p0, p1, p2); else n_pass++;
    n_chk++; if (bus.tag_o !== tg) $display("FAIL rb_tag: got %h want %h", bus.tag_o, tg); else n_pass++;
    n_chk++; if (bus.auth_ok_o !== 1'b1) $display("FAIL rb_auth: got %b want 1", bus.auth_ok_o); else n_pass++;
    n_chk++; if (pvc != 3) $display("FAIL rb_pvld_count: got %0d want 3", pvc); else n_pass++;
  endtask

  task automatic test_reset_final();
    model_enc(nonce, c0, c1, c2, tg);
    drive_msg(nonce, c0, c1, c2, tg, 0, 1'b0, 1'b1, q0, q1, q2, edges, pvc, to_err, e_after, a_after);
    n_chk++; if (to_err) $display("FAIL rf_timeout: got timeout want completion"); else n_pass++;
    rst_n = 1'b0;
    @(negedge clk);
    n_chk++; if ({bus.ready_o, bus.plain_valid_o, bus.auth_ok_o, bus.end_o} !== 4'b0000 ||
                 bus.plain_o !== 64'd0 || bus.tag_o !== 128'd0)
      $display("FAIL rf_outputs: got rdy/pv/auth/end=%b%b%b%b plain=%h tag=%h want all 0",
               bus.ready_o, bus.plain_valid_o, bus.auth_ok_o, bus.end_o, bus.plain_o, bus.tag_o);
    else n_pass++;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++; if ({bus.ready_o, bus.plain_valid_o, bus.end_o} !== 3'b000)
      $display("FAIL rf_idle: got rdy/pv/end=%b%b%b want 000", bus.ready_o, bus.plain_valid_o, bus.end_o); else n_pass++;
    drive_msg(nonce, c0, c1, c2, tg, 0, 1'b0, 1'b0, q0, q1, q2, edges, pvc, to_err, e_after, a_after);
    n_chk++; if (to_err) $display("FAIL rf2_timeout: got timeout want completion"); else n_pass++;
    n_chk++; if (q0 !== p0 || q1 !== p1 || q2 !== p2)
      $display("FAIL rf2_plain: got %h %h %h want %h %h %h", q0, q1, q2, p0, p1, p2); else n_pass++;
    n_chk++; if (bus.tag_o !== tg || bus.auth_ok_o !== 1'b1)
      $display("FAIL rf2_tag_auth: got %h/%b want %h/1", bus.tag_o, bus.auth_ok_o, tg); else n_pass++;
    n_chk++; if (edges != 47) $display("FAIL rf2_latency: got %0d want 47", edges); else n_pass++;
  endtask

  task automatic test_back_to_back();
    model_enc(nonce2, c0, c1, c2, tg);
    drive_msg(nonce2, c0, c1, c2, tg, 0, 1'b0, 1'b0, q0, q1, q2, edges, pvc, to_err, e_after, a_after);
    n_chk++; if (to_err) $display("FAIL b2b_timeout: got timeout want completion"); else n_pass++;
    n_chk++; if (e_after !== 1'b0) $display("FAIL b2b_end_clear: got %b want 0", e_after); else n_pass++;
    n_chk++; if (a_after !== 1'b0) $display("FAIL b2b_auth_clear: got %b want 0", a_after); else n_pass++;
    n_chk++; if (q0 !== p0 || q1 !== p1 || q2 !== p2)
      $display("FAIL b2b_plain: got %h %h %h want %h %h %h", q0, q1, q2, p0, p1, p2); else n_pass++;
    n_chk++; if (bus.tag_o !== tg) $display("FAIL b2b_tag: got %h want %h", bus.tag_o, tg); else n_pass++;
    n_chk++; if (bus.auth_ok_o !== 1'b1 || bus.end_o !== 1'b1)
      $display("FAIL b2b_auth_end: got %b/%b want 1/1", bus.auth_ok_o, bus.end_o); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_roundtrip();
    test_bad_tag();
    test_bad_ct();
    test_robust();
    test_reset_final();
    test_roundtrip();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
